ref_gen_dt: RTL and testbench

- Gated reference-frequency generator for the DRSSTC controller, with complementary dead-time outputs.
- Produces a square reference whose half-period is CNT_MIN + inp clock cycles.
- Adds over the basic generator: enable with clean start/stop on full-period boundaries, tuning input sampled only at half-period boundaries, range clamping, and a complementary gate-drive pair (out_a/out_b) with programmable dead time.
- Sits between the frequency-tracking logic and the gate-drive output stage.

---
 rtl/ref_gen_dt.sv | 147 ++++++++++++++
 tb/tb_ref_gen_dt.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ref_gen_dt.sv
// ref_gen_dt
//   Gated reference-frequency generator with a complementary dead-time pair.
//   The reference square wave has a half-period of L = CNT_MIN + min(inp, GEN_PARAMETER)
//   clock cycles. Starting and stopping always happen on full-period boundaries.
//   Each edge of the reference releases the newly-active drive only after
//   DEAD_CYC cycles.
//
// Ports
//   clk_i         system clock, rising edge
//   rst_ni        asynchronous active-low reset
//   en_i          run request (level)
//   inp_i         half-period tuning code, sampled only at start and at each reload
//   ref_o         raw reference square wave
//   out_a_o       high-side drive: ref with a delayed rising edge
//   out_b_o       low-side drive: ~ref with a delayed rising edge, only while busy
//   half_done_o   one-cycle pulse on every ref toggle, including the start toggle
//   busy_o        generator is running
module ref_gen_dt #(
  parameter int CLK_MHZ       = 100,
  parameter int FREQ_MID_KHZ  = 200,
  parameter int GEN_PARAMETER = 255,
  parameter int DEAD_CYC      = 4
) (
  input  logic                                 clk_i,
  input  logic                                 rst_ni,
  input  logic                                 en_i,
  input  logic [$clog2(GEN_PARAMETER+1)-1:0]   inp_i,
  output logic                                 ref_o,
  output logic                                 out_a_o,
  output logic                                 out_b_o,
  output logic                                 half_done_o,
  output logic                                 busy_o
);

  localparam int IW      = $clog2(GEN_PARAMETER + 1);
  localparam int CNT_MIN = (500 * CLK_MHZ) / FREQ_MID_KHZ - GEN_PARAMETER / 2;
  // Counter must hold the largest reload value CNT_MIN + GEN_PARAMETER - 1.
  localparam int CNT_W   = (CNT_MIN + GEN_PARAMETER > 2) ? $clog2(CNT_MIN + GEN_PARAMETER) : 1;
  localparam int DW      = (DEAD_CYC > 0) ? $clog2(DEAD_CYC + 1) : 1;

  if (CNT_MIN < 2) begin : g_bad_cnt_min
    $error("ref_gen_dt: CNT_MIN must be at least 2");
  end
  if (DEAD_CYC >= CNT_MIN) begin : g_bad_dead
    $error("ref_gen_dt: DEAD_CYC must be smaller than CNT_MIN");
  end

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  // Clamp the tuning code into the legal span.
  function automatic logic [IW-1:0] sat_inp(input logic [IW-1:0] x);
    if ({1'b0, x} > (IW+1)'(GEN_PARAMETER)) return IW'(GEN_PARAMETER);
    return x;
  endfunction

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [DW-1:0]    dcnt_q, dcnt_d;
  logic             ref_q, ref_d;
  logic             out_a_q, out_a_d;
  logic             out_b_q, out_b_d;
  logic             hd_q, hd_d;
  logic             busy_q, busy_d;
  logic [CNT_W-1:0] reload;

  // A reload of L-1 makes each ref level last exactly L cycles.
  assign reload = CNT_W'(CNT_MIN - 1) + CNT_W'(sat_inp(inp_i));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ref_d   = ref_q;
    hd_d    = 1'b0;
    dcnt_d  = dcnt_q;

    case (state_q)
      S_IDLE: begin
        if (en_i) begin
          state_d = S_RUN;
          ref_d   = 1'b1;
          cnt_d   = reload;
          hd_d    = 1'b1;
        end
      end
      S_RUN: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else if (ref_q) begin
          ref_d = 1'b0;
          cnt_d = reload;
          hd_d  = 1'b1;
        end else if (en_i) begin
          ref_d = 1'b1;
          cnt_d = reload;
          hd_d  = 1'b1;
        end else begin
          // Stop only at the end of a low half so the last period is whole.
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Dead-time counter restarts on every ref edge; drives wait for it to expire.
    if (ref_d != ref_q) begin
      dcnt_d = DW'(DEAD_CYC);
    end else if (dcnt_q != '0) begin
      dcnt_d = dcnt_q - DW'(1);
    end

    busy_d  = (state_d == S_RUN);
    out_a_d = ref_d & (dcnt_d == '0);
    out_b_d = ~ref_d & busy_d & (dcnt_d == '0);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      dcnt_q  <= '0;
      ref_q   <= 1'b0;
      out_a_q <= 1'b0;
      out_b_q <= 1'b0;
      hd_q    <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dcnt_q  <= dcnt_d;
      ref_q   <= ref_d;
      out_a_q <= out_a_d;
      out_b_q <= out_b_d;
      hd_q    <= hd_d;
      busy_q  <= busy_d;
    end
  end

  assign ref_o       = ref_q;
  assign out_a_o     = out_a_q;
  assign out_b_o     = out_b_q;
  assign half_done_o = hd_q;
  assign busy_o      = busy_q;

endmodule

// File: tb/tb_ref_gen_dt.sv
// Bench for ref_gen_dt. Three instances share one stimulus stream:
//   u0: defaults (CNT_MIN=123, DEAD_CYC=4)
//   u1: DEAD_CYC=0
//   u2: GEN_PARAMETER=200 (CNT_MIN=150)
// A timeline model predicts every output each cycle; directed measurements
// pin half-period lengths and drive-pulse widths to hand-computed numbers.
module tb_ref_gen_dt;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic [7:0] inp = 8'd127;
  logic [2:0] ref_w, oa_w, ob_w, hd_w, by_w;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  ref_gen_dt #(.CLK_MHZ(100), .FREQ_MID_KHZ(200), .GEN_PARAMETER(255), .DEAD_CYC(4)) u0 (
    .clk_i(clk), .rst_ni(rst_n), .en_i(en), .inp_i(inp),
    .ref_o(ref_w[0]), .out_a_o(oa_w[0]), .out_b_o(ob_w[0]),
    .half_done_o(hd_w[0]), .busy_o(by_w[0]));

  ref_gen_dt #(.CLK_MHZ(100), .FREQ_MID_KHZ(200), .GEN_PARAMETER(255), .DEAD_CYC(0)) u1 (
    .clk_i(clk), .rst_ni(rst_n), .en_i(en), .inp_i(inp),
    .ref_o(ref_w[1]), .out_a_o(oa_w[1]), .out_b_o(ob_w[1]),
    .half_done_o(hd_w[1]), .busy_o(by_w[1]));

  ref_gen_dt #(.CLK_MHZ(100), .FREQ_MID_KHZ(200), .GEN_PARAMETER(200), .DEAD_CYC(4)) u2 (
    .clk_i(clk), .rst_ni(rst_n), .en_i(en), .inp_i(inp),
    .ref_o(ref_w[2]), .out_a_o(oa_w[2]), .out_b_o(ob_w[2]),
    .half_done_o(hd_w[2]), .busy_o(by_w[2]));

  localparam int CMV [3] = '{123, 123, 150};
  localparam int GPV [3] = '{255, 255, 200};
  localparam int DV  [3] = '{4, 0, 4};

  // ---------------- timeline model ----------------
  int cyc;
  bit m_run [3];
  bit m_ref [3];
  bit m_hd  [3];
  int m_next[3];   // cycle at which the current half ends
  int m_edge[3];   // cycle of the most recent ref edge

  function automatic int half_len(input int k, input int code);
    return CMV[k] + ((code > GPV[k]) ? GPV[k] : code);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc <= 0;
      for (int k = 0; k < 3; k++) begin
        m_run[k]  <= 1'b0;
        m_ref[k]  <= 1'b0;
        m_hd[k]   <= 1'b0;
        m_next[k] <= 0;
        m_edge[k] <= 0;
      end
    end else begin
      cyc <= cyc + 1;
      for (int k = 0; k < 3; k++) begin
        m_hd[k] <= 1'b0;
        if (!m_run[k]) begin
          if (en) begin
            m_run[k]  <= 1'b1;
            m_ref[k]  <= 1'b1;
            m_hd[k]   <= 1'b1;
            m_next[k] <= cyc + 1 + half_len(k, int'(inp));
            m_edge[k] <= cyc + 1;
          end
        end else if (cyc + 1 == m_next[k]) begin
          if (m_ref[k] || en) begin
            m_ref[k]  <= !m_ref[k];
            m_hd[k]   <= 1'b1;
            m_next[k] <= cyc + 1 + half_len(k, int'(inp));
            m_edge[k] <= cyc + 1;
          end else begin
            m_run[k] <= 1'b0;
          end
        end
      end
    end
  end

  // Output order: {ref, out_a, out_b, half_done, busy}
  function automatic logic [4:0] model_vec(input int k);
    bit settled;
    settled = (cyc - m_edge[k]) >= DV[k];
    return {m_ref[k], m_ref[k] & settled, m_run[k] & ~m_ref[k] & settled, m_hd[k], m_run[k]};
  endfunction

  function automatic logic [4:0] dut_vec(input int k);
    return {ref_w[k], oa_w[k], ob_w[k], hd_w[k], by_w[k]};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      check($sformatf("model_k%0d", k), 32'(dut_vec(k)), 32'(model_vec(k)));
      check($sformatf("overlap_k%0d", k), 32'(oa_w[k] & ob_w[k]), 32'd0);
    end
  end

  // ---------------- directed helpers ----------------
  task automatic wait_ref(input int k, input logic v);
    int n;
    n = 0;
    while (ref_w[k] !== v && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check($sformatf("wait_ref_k%0d", k), 32'(ref_w[k]), 32'(v));
  endtask

  // Counts the cycles ref stays at v while busy, starting at the current
  // negedge. At cycle 'at' applies act (1: inp=val, 2: en=val).
  task automatic measure(input int k, input logic v, input int at, input int act, input int val,
                         output int n, output int na, output int nb, output int nh);
    n = 0; na = 0; nb = 0; nh = 0;
    while (ref_w[k] === v && by_w[k] === 1'b1 && n < 3000) begin
      n++;
      na += int'(oa_w[k]);
      nb += int'(ob_w[k]);
      nh += int'(hd_w[k]);
      if (n == at) begin
        if (act == 1) inp = val[7:0];
        else if (act == 2) en = val[0];
      end
      @(negedge clk);
    end
  endtask

  initial begin
    int n, na, nb, nh, bad;

    rst_n = 1'b0; en = 1'b0; inp = 8'd127;
    repeat (3) @(negedge clk);
    for (int k = 0; k < 3; k++) check($sformatf("reset_k%0d", k), 32'(dut_vec(k)), 32'd0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    check("idle_no_start", 32'(dut_vec(0)), 32'd0);

    // start, inp=127 -> L=250
    en = 1'b1;
    @(negedge clk);
    check("start_k0", 32'(dut_vec(0)), 32'b10011);
    check("start_k1", 32'(dut_vec(1)), 32'b11011);
    measure(0, 1'b1, 0, 0, 0, n, na, nb, nh);
    check("high_len", n, 250);
    check("high_out_a", na, 246);
    check("high_hd", nh, 1);
    measure(0, 1'b0, 0, 0, 0, n, na, nb, nh);
    check("low_len", n, 250);
    check("low_out_b", nb, 246);
    check("low_out_a", na, 0);

    // inp=0, then 255 in the middle of a high half
    inp = 8'd0;
    wait_ref(0, 1'b0);
    wait_ref(0, 1'b1);
    measure(0, 1'b1, 10, 1, 255, n, na, nb, nh);
    check("tune_high_len", n, 123);
    measure(0, 1'b0, 0, 0, 0, n, na, nb, nh);
    check("tune_low_len", n, 378);
    check("tune_low_hd", nh, 1);

    // clamp on GEN_PARAMETER=200 instance
    inp = 8'd250;
    wait_ref(2, 1'b0);
    wait_ref(2, 1'b1);
    measure(2, 1'b1, 0, 0, 0, n, na, nb, nh);
    check("clamp_250", n, 350);
    inp = 8'd200;
    wait_ref(2, 1'b0);
    wait_ref(2, 1'b1);
    measure(2, 1'b1, 0, 0, 0, n, na, nb, nh);
    check("clamp_200", n, 350);

    // stop: en dropped 10 cycles into a high half
    inp = 8'd127;
    wait_ref(0, 1'b0);
    wait_ref(0, 1'b1);
    measure(0, 1'b1, 10, 2, 0, n, na, nb, nh);
    check("stop_high_len", n, 250);
    measure(0, 1'b0, 0, 0, 0, n, na, nb, nh);
    check("stop_low_len", n, 250);
    check("stop_low_out_b", nb, 246);
    check("stopped_k0", 32'(dut_vec(0)), 32'd0);
    check("stopped_k1", 32'(dut_vec(1)), 32'd0);
    repeat (20) @(negedge clk);
    check("still_idle", 32'(dut_vec(0)), 32'd0);

    // restart, drop en, then re-raise 5 cycles before end of low
    en = 1'b1;
    @(negedge clk);
    check("restart_k0", 32'(dut_vec(0)), 32'b10011);
    measure(0, 1'b1, 10, 2, 0, n, na, nb, nh);
    check("rearm_high_len", n, 250);
    measure(0, 1'b0, 245, 2, 1, n, na, nb, nh);
    check("rearm_low_len", n, 250);
    check("rearm_busy_ref", 32'({by_w[0], ref_w[0]}), 32'b11);
    measure(0, 1'b1, 0, 0, 0, n, na, nb, nh);
    check("rearm_next_high", n, 250);

    // asynchronous reset mid-run
    repeat (37) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) check($sformatf("async_reset_k%0d", k), 32'(dut_vec(k)), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_reset_k0", 32'(dut_vec(0)), 32'b10011);
    check("post_reset_k1", 32'(dut_vec(1)), 32'b11011);
    measure(0, 1'b1, 0, 0, 0, n, na, nb, nh);
    check("post_reset_high", n, 250);

    // DEAD_CYC=0 instance follows ref exactly
    bad = 0;
    repeat (600) begin
      @(negedge clk);
      if (oa_w[1] !== ref_w[1] || ob_w[1] !== (~ref_w[1] & by_w[1])) bad++;
    end
    check("dead0_follow", bad, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
